// File: rtl/tick_ctrl_pkg.sv
// Shared types for the tick_ctrl run-control stage: state encoding seen on STATE_O
// and the BCD all-zero test used by the FSM and strobe gating.
package tick_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } tick_state_e;

    function automatic logic bcd_is_zero(input logic [3:0] d1,
                                         input logic [3:0] d2,
                                         input logic [3:0] d3);
        return (d1 == 4'd0) && (d2 == 4'd0) && (d3 == 4'd0);
    endfunction

endpackage

// File: rtl/tick_ctrl_if.sv
// Link between tick_ctrl and the three-digit BCD seconds down-counter.
interface tick_ctrl_if;
    logic [3:0] TIM_1;
    logic [3:0] TIM_2;
    logic [3:0] TIM_3;
    logic       pulse_1sec;
    logic       TIMEOUT;

    modport master (input TIM_1, TIM_2, TIM_3, output pulse_1sec, TIMEOUT);
    modport slave  (output TIM_1, TIM_2, TIM_3, input pulse_1sec, TIMEOUT);
endinterface

// File: rtl/tick_ctrl_btn_cond.sv
// Button conditioner: two-flop synchronizer, debounce counter and a one-cycle
// rising-edge event on the accepted level.
module btn_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // cnt tracks how many consecutive samples have disagreed with the accepted level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/tick_ctrl.sv
// Run-control for the BCD seconds down-counter: 1 s strobe, IDLE/RUN/PAUSE/EXPIRED FSM.
// Optional blinking alarm output when TICK_CTRL_ALARM_EN is defined.
module tick_ctrl
    import tick_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic              CLK_I,
    input  logic              SW_RESET_I,
    input  logic              START_I,
    input  logic              PAUSE_I,
    tick_ctrl_if.master       cnt,
    output logic [1:0]        STATE_O,
    output logic              ALARM_O
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    tick_state_e   state;
    tick_state_e   state_nxt;
    logic          start_ev;
    logic          pause_ev;
    logic          zero;
    logic          presc_clr;
    logic [PW-1:0] presc;
    logic          pulse_q;
    logic          timeout;

    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk  (CLK_I),
        .rst  (SW_RESET_I),
        .btn  (START_I),
        .rise (start_ev)
    );

    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .clk  (CLK_I),
        .rst  (SW_RESET_I),
        .btn  (PAUSE_I),
        .rise (pause_ev)
    );

    assign zero = bcd_is_zero(cnt.TIM_1, cnt.TIM_2, cnt.TIM_3);

    always_ff @(posedge CLK_I) begin
        if (SW_RESET_I) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        presc_clr = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ev) begin
                    presc_clr = 1'b1;
                    state_nxt = zero ? ST_EXPIRED : ST_RUN;
                end
            end
            ST_RUN: begin
                if (zero)          state_nxt = ST_EXPIRED;
                else if (pause_ev) state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (start_ev) state_nxt = ST_RUN;
            end
            ST_EXPIRED: state_nxt = ST_EXPIRED;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (SW_RESET_I) begin
            presc   <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (presc_clr) begin
                presc <= '0;
            end else if (state == ST_RUN) begin
                if (presc == PRESC_MAX) begin
                    presc   <= '0;
                    pulse_q <= ~zero;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    // Gate the registered strobe with the live count so 000 can never be decremented.
    assign cnt.pulse_1sec = pulse_q & ~zero;

    assign timeout     = (state == ST_EXPIRED);
    assign cnt.TIMEOUT = timeout;
    assign STATE_O     = state;

`ifdef TICK_CTRL_ALARM_EN
    localparam int unsigned HALF = TICK_DIV / 2;
    localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

    logic [BW-1:0] blink_cnt;
    logic          alarm_q;

    always_ff @(posedge CLK_I) begin
        if (SW_RESET_I) begin
            blink_cnt <= '0;
            alarm_q   <= 1'b0;
        end else if (state_nxt == ST_EXPIRED && state != ST_EXPIRED) begin
            blink_cnt <= '0;
            alarm_q   <= 1'b1;
        end else if (state == ST_EXPIRED) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt <= '0;
                alarm_q   <= ~alarm_q;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign ALARM_O = alarm_q;
`else
    assign ALARM_O = timeout;
`endif

endmodule

// File: tb/tb_tick_ctrl.sv
// Self-checking bench for tick_ctrl against a cycle-level behavioural reference model.
module tb_tick_ctrl;
    localparam int TD = 10;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pause;
    logic [1:0] state_o;
    logic       alarm_o;

    tick_ctrl_if cnt();

    tick_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .CLK_I      (clk),
        .SW_RESET_I (rst),
        .START_I    (start),
        .PAUSE_I    (pause),
        .cnt        (cnt),
        .STATE_O    (state_o),
        .ALARM_O    (alarm_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int start_left = 0;
    int pause_left = 0;

    // Reference model: run-edge count since clear, sample windows per button.
    int         m_state = 0;
    int         m_runs = 0;
    int         m_k = 0;
    bit         m_pulse = 1'b0;
    bit [1:0]   m_sp  [2];
    bit [DB-1:0] m_win [2];
    bit         m_lvl  [2];
    bit         m_pend [2];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit tim_zero();
        return cnt.TIM_1 == 4'd0 && cnt.TIM_2 == 4'd0 && cnt.TIM_3 == 4'd0;
    endfunction

    function automatic int exp_alarm();
`ifdef TICK_CTRL_ALARM_EN
        return (m_state == 3 && ((m_k / (TD / 2)) % 2 == 0)) ? 1 : 0;
`else
        return (m_state == 3) ? 1 : 0;
`endif
    endfunction

    function automatic void model_edge();
        bit raw [2];
        bit ev  [2];
        bit s;
        int prev;
        raw[0] = start;
        raw[1] = pause;
        if (rst) begin
            m_state = 0; m_runs = 0; m_k = 0; m_pulse = 1'b0;
            for (int b = 0; b < 2; b++) begin
                m_sp[b] = '0; m_win[b] = '0; m_lvl[b] = 1'b0; m_pend[b] = 1'b0;
            end
            return;
        end
        for (int b = 0; b < 2; b++) begin
            ev[b]     = m_pend[b];
            s         = m_sp[b][1];
            m_sp[b]   = {m_sp[b][0], raw[b]};
            m_win[b]  = {m_win[b][DB-2:0], s};
            m_pend[b] = 1'b0;
            if (m_win[b] == {DB{~m_lvl[b]}}) begin
                m_lvl[b]  = ~m_lvl[b];
                m_pend[b] = m_lvl[b];
            end
        end
        m_pulse = 1'b0;
        if (m_state == 1) begin
            m_runs++;
            if (m_runs % TD == 0) m_pulse = !tim_zero();
        end
        prev = m_state;
        case (m_state)
            0: if (ev[0]) begin m_runs = 0; m_state = tim_zero() ? 3 : 1; end
            1: if (tim_zero()) m_state = 3; else if (ev[1]) m_state = 2;
            2: if (ev[0]) m_state = 1;
            default: ;
        endcase
        if (m_state == 3) m_k = (prev == 3) ? m_k + 1 : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("state",   state_o, m_state);
        check("timeout", cnt.TIMEOUT, (m_state == 3) ? 1 : 0);
        check("pulse",   cnt.pulse_1sec, (m_pulse && !tim_zero()) ? 1 : 0);
        check("alarm",   alarm_o, exp_alarm());
        if (start_left > 0) begin start_left--; if (start_left == 0) start = 1'b0; end
        if (pause_left > 0) begin pause_left--; if (pause_left == 0) pause = 1'b0; end
    endtask

    task automatic set_tim(input int d1, input int d2, input int d3);
        cnt.TIM_1 = 4'(d1);
        cnt.TIM_2 = 4'(d2);
        cnt.TIM_3 = 4'(d3);
    endtask

    task automatic press_start(input int len);
        start = 1'b1; start_left = len;
    endtask

    task automatic press_pause(input int len);
        pause = 1'b1; pause_left = len;
    endtask

    task automatic wait_state(input int target, input int max, output int n);
        n = 0;
        do begin step(); n++; end while (state_o != 2'(target) && n < max);
    endtask

    task automatic count_to_pulse(input int max, output int n);
        n = 0;
        do begin step(); n++; end while (!cnt.pulse_1sec && n < max);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        int toggles;
        logic prev_alarm;

        rst = 1'b1; start = 1'b0; pause = 1'b0;
        set_tim(0, 3, 0);
        step(); step();
        rst = 1'b0;
        step();
        check("reset_state", state_o, 0);
        check("reset_pulse", cnt.pulse_1sec, 0);
        check("reset_alarm", alarm_o, 0);

        // Start, first pulse and period
        press_start(10);
        wait_state(1, 20, n);    check("start_latency", n, 7);
        count_to_pulse(30, n);   check("first_pulse", n, 10);
        count_to_pulse(30, n);   check("pulse_period", n, 10);

        // Pause lands with prescaler held at 6
        repeat (9) step();
        press_pause(6);
        wait_state(2, 20, n);    check("pause_latency", n, 7);
        pulses = 0;
        repeat (20) begin step(); pulses += int'(cnt.pulse_1sec); end
        check("pause_no_pulse", pulses, 0);
        check("pause_held", state_o, 2);
        press_start(6);
        wait_state(1, 20, n);    check("resume_latency", n, 7);
        count_to_pulse(30, n);   check("resume_pulse", n, 4);

        // Simultaneous START and PAUSE in RUN
        repeat (14) step();
        press_start(6); press_pause(6);
        wait_state(2, 20, n);    check("both_pause", n, 7);

        // Chatter shorter than the debounce window
        repeat (12) step();
        repeat (4) begin
            start = 1'b1; pause = 1'b1; repeat (3) step();
            start = 1'b0; pause = 1'b0; repeat (3) step();
        end
        repeat (10) step();
        check("chatter_state", state_o, 2);

        // Count reaches 000 in RUN
        press_start(6);
        wait_state(1, 20, n);    check("resume2_state", state_o, 1);
        repeat (5) step();
        set_tim(0, 0, 0);
        step();
        check("zero_timeout", cnt.TIMEOUT, 1);
        check("zero_state", state_o, 3);
        pulses = 0; toggles = 0; prev_alarm = alarm_o;
        repeat (30) begin
            step();
            pulses += int'(cnt.pulse_1sec);
            if (alarm_o != prev_alarm) toggles++;
            prev_alarm = alarm_o;
        end
        check("zero_no_pulse", pulses, 0);
`ifdef TICK_CTRL_ALARM_EN
        check("alarm_toggles", toggles, 6);
`else
        check("alarm_toggles", toggles, 0);
        check("alarm_steady", alarm_o, 1);
`endif

        // START in IDLE with count already 000
        rst = 1'b1; step(); rst = 1'b0;
        press_start(6);
        wait_state(3, 20, n);    check("idle_zero_expired", n, 7);
        pulses = 0;
        repeat (30) begin step(); pulses += int'(cnt.pulse_1sec); end
        check("idle_zero_no_pulse", pulses, 0);

        // Reset mid-RUN
        set_tim(5, 4, 1);
        rst = 1'b1; step(); rst = 1'b0;
        press_start(6);
        wait_state(1, 20, n);
        repeat (13) step();
        rst = 1'b1; step(); rst = 1'b0;
        check("midrst_state", state_o, 0);
        check("midrst_pulse", cnt.pulse_1sec, 0);
        repeat (12) step();
        press_start(6);
        wait_state(1, 20, n);    check("midrst_start", n, 7);
        count_to_pulse(30, n);   check("midrst_first_pulse", n, 10);

        // Randomized traffic
        rst = 1'b1; step(); rst = 1'b0;
        repeat (1500) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4 && start_left == 0) press_start(int'($urandom_range(1, 12)));
            else if (r < 8 && pause_left == 0) press_pause(int'($urandom_range(1, 12)));
            else if (r < 10) begin
                if ($urandom_range(0, 5) == 0) set_tim(0, 0, 0);
                else set_tim(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                             int'($urandom_range(0, 9)));
            end
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
